// File: rtl/serial_bus_master_pkg.sv
// Shared definitions for the serial bus: frame start code, FSM states and width helpers.
package serial_bus_master_pkg;

  localparam logic [2:0] START = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    CTRL,
    WAIT_RDY,
    WDATA,
    RDATA,
    FINISH
  } state_e;

  function automatic int unsigned addr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

  function automatic int unsigned s_id_width(input int unsigned slaves);
    return $clog2(slaves + 1);
  endfunction

  function automatic int unsigned len_width(input int unsigned max_burst);
    return $clog2(max_burst + 1);
  endfunction

  // Frame layout: {START, slave, rw, burst, addr}
  function automatic int unsigned con_len(input int unsigned sid_w, input int unsigned addr_w);
    return 3 + sid_w + 2 + addr_w;
  endfunction

endpackage

// File: rtl/serial_bus_master_if.sv
// Serial bus wires between a master and the interconnect/slave side.
interface serial_bus_master_if;
  logic control;
  logic wD;
  logic valid;
  logic last;
  logic rD;
  logic ready;

  modport master (output control, wD, valid, last, input rD, ready);
  modport slave  (input control, wD, valid, last, output rD, ready);
endinterface

// File: rtl/serial_bus_master_shift_reg.sv
// MSB-first shift register with parallel load, shift-out and LSB shift-in.
module serial_bus_master_shift_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             shift_i,
  input  logic             sin_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = data_i;
    end else if (shift_i) begin
      sr_d = {sr_q[WIDTH-2:0], sin_i};
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) sr_q <= '0;
    else       sr_q <= sr_d;
  end

  assign q_o = sr_q;
endmodule

// File: rtl/serial_bus_master.sv
// Serial bus initiator: shifts out the control frame, then streams write words or
// collects read words, with ready timeout and illegal-request detection.
module serial_bus_master
  import serial_bus_master_pkg::*;
#(
  parameter int unsigned ADDR_DEPTH = 2000,
  parameter int unsigned SLAVES     = 3,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 16,
  parameter int unsigned TIMEOUT    = 1024,
  localparam int unsigned ADDR_WIDTH = addr_width(ADDR_DEPTH),
  localparam int unsigned S_ID_WIDTH = s_id_width(SLAVES),
  localparam int unsigned LEN_WIDTH  = len_width(MAX_BURST)
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  req,
  input  logic                  req_rw,
  input  logic [S_ID_WIDTH-1:0] req_slave,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]  req_len,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ack,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  serial_bus_master_if.master   bus
);
  localparam int unsigned CON_LEN = con_len(S_ID_WIDTH, ADDR_WIDTH);
  localparam int unsigned FCNT_W  = $clog2(CON_LEN) + 1;
  localparam int unsigned BCNT_W  = $clog2(DATA_WIDTH) + 1;
  localparam int unsigned TCNT_W  = $clog2(TIMEOUT) + 1;

  state_e state_q, state_d;

  logic                  rw_q, rw_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic                  err_pend_q, err_pend_d;
  logic                  seen_low_q, seen_low_d;
  logic [FCNT_W-1:0]     frm_cnt_q, frm_cnt_d;
  logic [BCNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [LEN_WIDTH-1:0]  word_cnt_q, word_cnt_d;
  logic [TCNT_W-1:0]     to_cnt_q, to_cnt_d;

  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  wr_ack_q, wr_ack_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  control_q, control_d;
  logic                  wd_q, wd_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;

  logic                  frm_load_c, frm_shift_c;
  logic                  wr_load_c, wr_shift_c;
  logic                  rd_shift_c;
  logic [CON_LEN-1:0]    frame_c;
  logic [CON_LEN-1:0]    frm_q;
  logic [DATA_WIDTH-1:0] wr_q, rd_q;

  logic req_ok_c, frm_end_c, bit_end_c, word_end_c, to_end_c, wr_go_c, rd_go_c;

  assign req_ok_c   = (req_len != '0) && (req_len <= LEN_WIDTH'(MAX_BURST)) &&
                      (req_slave != '0) && (req_slave <= S_ID_WIDTH'(SLAVES));
  assign frame_c    = {START, req_slave, req_rw, (req_len > LEN_WIDTH'(1)), req_addr};
  assign frm_end_c  = (frm_cnt_q == FCNT_W'(CON_LEN - 1));
  assign bit_end_c  = (bit_cnt_q == BCNT_W'(DATA_WIDTH - 1));
  assign word_end_c = (LEN_WIDTH'(word_cnt_q + 1'b1) == len_q);
  assign to_end_c   = (to_cnt_q == TCNT_W'(TIMEOUT - 1));
  assign wr_go_c    = rw_q && bus.ready;
  // Reads need a fresh low-to-high ready edge so a stale ready is not taken as data.
  assign rd_go_c    = !rw_q && bus.ready && seen_low_q;

  serial_bus_master_shift_reg #(.WIDTH(CON_LEN)) u_frm_sr (
    .clk    (clk),
    .rstN   (rstN),
    .load_i (frm_load_c),
    .data_i (frame_c),
    .shift_i(frm_shift_c),
    .sin_i  (1'b0),
    .q_o    (frm_q)
  );

  serial_bus_master_shift_reg #(.WIDTH(DATA_WIDTH)) u_wr_sr (
    .clk    (clk),
    .rstN   (rstN),
    .load_i (wr_load_c),
    .data_i (wr_data),
    .shift_i(wr_shift_c),
    .sin_i  (1'b0),
    .q_o    (wr_q)
  );

  serial_bus_master_shift_reg #(.WIDTH(DATA_WIDTH)) u_rd_sr (
    .clk    (clk),
    .rstN   (rstN),
    .load_i (1'b0),
    .data_i ('0),
    .shift_i(rd_shift_c),
    .sin_i  (bus.rD),
    .q_o    (rd_q)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (req && !busy_q) state_d = req_ok_c ? CTRL : FINISH;
      CTRL:     if (frm_end_c) state_d = WAIT_RDY;
      WAIT_RDY: begin
        if (wr_go_c)       state_d = WDATA;
        else if (rd_go_c)  state_d = RDATA;
        else if (to_end_c) state_d = IDLE;
      end
      WDATA:    if (bit_end_c && word_end_c) state_d = FINISH;
      RDATA:    if (bus.ready && bit_end_c && word_end_c) state_d = FINISH;
      FINISH:   state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    rw_d        = rw_q;
    len_d       = len_q;
    err_pend_d  = err_pend_q;
    seen_low_d  = seen_low_q;
    frm_cnt_d   = frm_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    word_cnt_d  = word_cnt_q;
    to_cnt_d    = to_cnt_q;
    busy_d      = busy_q;
    rd_data_d   = rd_data_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    wr_ack_d    = 1'b0;
    rd_valid_d  = 1'b0;
    control_d   = 1'b0;
    wd_d        = 1'b0;
    valid_d     = 1'b0;
    last_d      = 1'b0;
    frm_load_c  = 1'b0;
    frm_shift_c = 1'b0;
    wr_load_c   = 1'b0;
    wr_shift_c  = 1'b0;
    rd_shift_c  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req && !busy_q) begin
          busy_d     = 1'b1;
          rw_d       = req_rw;
          len_d      = req_len;
          err_pend_d = !req_ok_c;
          frm_load_c = req_ok_c;
          frm_cnt_d  = '0;
        end
      end
      CTRL: begin
        control_d   = frm_q[CON_LEN-1];
        frm_shift_c = 1'b1;
        frm_cnt_d   = frm_cnt_q + 1'b1;
        if (frm_end_c) begin
          to_cnt_d   = '0;
          seen_low_d = 1'b0;
        end
      end
      WAIT_RDY: begin
        if (wr_go_c) begin
          wr_load_c  = 1'b1;
          wr_ack_d   = 1'b1;
          bit_cnt_d  = '0;
          word_cnt_d = '0;
        end else if (rd_go_c) begin
          rd_shift_c = 1'b1;
          bit_cnt_d  = BCNT_W'(1);
          word_cnt_d = '0;
        end else if (to_end_c) begin
          done_d = 1'b1;
          err_d  = 1'b1;
          busy_d = 1'b0;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
        if (!bus.ready) seen_low_d = 1'b1;
      end
      WDATA: begin
        valid_d = 1'b1;
        wd_d    = wr_q[DATA_WIDTH-1];
        if (bit_end_c) begin
          bit_cnt_d  = '0;
          word_cnt_d = word_cnt_q + 1'b1;
          // Reload on the final bit so the next word follows with no valid gap.
          if (!word_end_c) begin
            wr_load_c = 1'b1;
            wr_ack_d  = 1'b1;
          end
        end else begin
          wr_shift_c = 1'b1;
          bit_cnt_d  = bit_cnt_q + 1'b1;
        end
      end
      RDATA: begin
        if (bus.ready) begin
          rd_shift_c = 1'b1;
          if (bit_end_c) begin
            rd_data_d  = {rd_q[DATA_WIDTH-2:0], bus.rD};
            rd_valid_d = 1'b1;
            bit_cnt_d  = '0;
            word_cnt_d = word_cnt_q + 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      FINISH: begin
        done_d = 1'b1;
        err_d  = err_pend_q;
        last_d = !err_pend_q;
        busy_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rw_q       <= 1'b0;
      len_q      <= '0;
      err_pend_q <= 1'b0;
      seen_low_q <= 1'b0;
      frm_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      to_cnt_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      wr_ack_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      control_q  <= 1'b0;
      wd_q       <= 1'b0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      rw_q       <= rw_d;
      len_q      <= len_d;
      err_pend_q <= err_pend_d;
      seen_low_q <= seen_low_d;
      frm_cnt_q  <= frm_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      to_cnt_q   <= to_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      wr_ack_q   <= wr_ack_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      control_q  <= control_d;
      wd_q       <= wd_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign wr_ack      = wr_ack_q;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign bus.control = control_q;
  assign bus.wD      = wd_q;
  assign bus.valid   = valid_q;
  assign bus.last    = last_q;

  // Only the serial ends of the shifters are consumed.
  logic unused_c;
  assign unused_c = ^{frm_q[CON_LEN-2:0], wr_q[DATA_WIDTH-2:0], rd_q[DATA_WIDTH-1]};
endmodule
